mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Schedules the single byte-serial RAM transfer engine between instruction fetch (IF) and the
//  load/store buffer (LSB). Grants one whole transaction at a time with LSB priority, plus an IF
//  anti-starvation limit. Stalls stores to the IO window while the UART buffer is full. Discards
//  in-flight speculative results on jump_wrong and returns results as one-cycle pulses to IF, LSB and the load CDB.
// PARAMETERS
//  ROB_W       4             ROB id width (equals `ROBBW)
//  IO_BASE     32'h0003_0000 addresses >= IO_BASE are IO space
//  STARVE_MAX  3             consecutive LSB grants while IF waits before IF is forced
// PORTS
//  clk            in  1      system clock
//  rst            in  1      asynchronous reset, active-high
//  rdy            in  1      global enable; low = freeze all state, no new eng_start
//  io_buffer_full in  1      UART tx buffer full
//  jump_wrong     in  1      misprediction flush
//  if_req         in  1      IF wants a 32-bit fetch, held until if_valid
//  if_addr        in  32     fetch address
//  if_valid       out 1      one-cycle pulse, if_inst valid
//  if_inst        out 32     fetched instruction
//  lsb_req        in  1      LSB request, held until lsb_done
//  lsb_type       in  1      0 load, 1 store
//  lsb_width      in  2      0 byte, 1 half, 3 word (2 illegal, treated as 3)
//  lsb_addr       in  32     access address
//  lsb_val        in  32     store data
//  lsb_rob_id     in  ROB_W  ROB tag of the load
//  lsb_done       out 1      one-cycle pulse, LSB transaction retired
//  ld_cdb_flag    out 1      one-cycle pulse, load result broadcast
//  ld_cdb_val     out 32     zero-extended load data
//  ld_cdb_rob_id  out ROB_W  tag latched at grant
//  eng_start      out 1      one-cycle pulse starting an engine transaction
//  eng_wr         out 1      0 read, 1 write
//  eng_addr       out 32     base address (held stable from eng_start to eng_done)
//  eng_width      out 2      bytes-1 of transaction
//  eng_wdata      out 32     write data (held stable from eng_start to eng_done)
//  eng_done       in  1      engine finished; eng_rdata valid this cycle
//  eng_rdata      in  32     assembled little-endian read data, zero-extended
// BEHAVIOUR
//  - Reset: state=IDLE, all pulses 0, all data/addr outputs 0, starve_cnt=0.
//  - States: IDLE, RUN_IF, RUN_LS, IO_WAIT, DRAIN. All outputs are registered.
//  - IDLE, rdy=1, arbitration in this order:
//      1) lsb_req and (if_req=0 or starve_cnt<STARVE_MAX) -> LSB.
//      2) if_req -> IF (eng_width=3, eng_wr=0).
//  - LSB grant: if store and addr>=IO_BASE and io_buffer_full -> IO_WAIT; else -> RUN_LS.
//    Address/data/tag are latched at grant.
//  - eng_start is asserted on the cycle after the grant decision. First grant latency = 1 clk.
//  - IO_WAIT: hold until io_buffer_full=0, then pulse eng_start and go to RUN_LS.
//    jump_wrong does not cancel it (stores are committed).
//  - RUN_IF + eng_done: next cycle if_valid=1, if_inst=eng_rdata; -> IDLE.
//  - RUN_LS + eng_done: next cycle lsb_done=1.
//    If load, also ld_cdb_flag=1, ld_cdb_val=eng_rdata, ld_cdb_rob_id=latched tag. -> IDLE.
//  - starve_cnt: +1 (saturating) on each LSB grant while if_req=1; cleared on any IF grant.
//  - jump_wrong in RUN_IF, or in RUN_LS carrying a load -> DRAIN.
//    DRAIN waits for eng_done, suppresses all result pulses, then -> IDLE.
//    A store in RUN_LS or IO_WAIT completes normally.
//  - jump_wrong in IDLE blocks any grant that cycle and clears starve_cnt.
//  - No new grant in the cycle a result pulse is emitted, giving a 1-cycle gap between transactions.
//  - rdy=0: state, counters and outputs hold, and pulses deassert. eng_done is ignored while rdy=0
//    (the engine is frozen by the same rdy).
//  - Async rst mid-transaction: immediately forces IDLE, outputs 0; the engine is reset by the same rst.
// TESTING
//  - Lone fetch: if_req, if_addr=0x100, eng_done 4 clks after eng_start with rdata=0x00500093
//    -> eng_start 1 clk after request; if_valid pulse with if_inst=0x00500093.
//  - Contention: if_req and lsb_req (load word @0x200, rob 5) together -> LSB first;
//    ld_cdb_val=eng_rdata, rob_id=5; IF granted next.
//  - Starvation: lsb_req held high with 4 back-to-back loads while if_req=1
//    -> IF granted after the 3rd LSB transaction.
//  - IO stall: store byte 0x41 @0x30000 with io_buffer_full=1 for 10 clks
//    -> no eng_start until the cycle after full drops; then lsb_done, no ld_cdb_flag.
//  - Flush: jump_wrong 2 clks into an IF transaction -> no if_valid;
//    next eng_start only after eng_done. Repeat during a store -> lsb_done still pulses.
//  - rdy low for 5 clks mid-RUN_LS and async rst pulse mid-RUN_IF
//    -> state frozen then resumed; rst returns all outputs to 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/result and engine bus between IF, LSB, the RAM engine and the arbiter.
// slave is the arbiter's view; master is the requesters' and engine's view.
interface mem_arbiter_if #(
    parameter int ROB_W = 4
);
    logic             rdy;
    logic             io_buffer_full;
    logic             jump_wrong;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_valid;
    logic [31:0]      if_inst;
    logic             lsb_req;
    logic             lsb_type;
    logic [1:0]       lsb_width;
    logic [31:0]      lsb_addr;
    logic [31:0]      lsb_val;
    logic [ROB_W-1:0] lsb_rob_id;
    logic             lsb_done;
    logic             ld_cdb_flag;
    logic [31:0]      ld_cdb_val;
    logic [ROB_W-1:0] ld_cdb_rob_id;
    logic             eng_start;
    logic             eng_wr;
    logic [31:0]      eng_addr;
    logic [1:0]       eng_width;
    logic [31:0]      eng_wdata;
    logic             eng_done;
    logic [31:0]      eng_rdata;

    modport slave (
        input  rdy, io_buffer_full, jump_wrong, if_req, if_addr, lsb_req, lsb_type, lsb_width,
               lsb_addr, lsb_val, lsb_rob_id, eng_done, eng_rdata,
        output if_valid, if_inst, lsb_done, ld_cdb_flag, ld_cdb_val, ld_cdb_rob_id,
               eng_start, eng_wr, eng_addr, eng_width, eng_wdata
    );

    modport master (
        output rdy, io_buffer_full, jump_wrong, if_req, if_addr, lsb_req, lsb_type, lsb_width,
               lsb_addr, lsb_val, lsb_rob_id, eng_done, eng_rdata,
        input  if_valid, if_inst, lsb_done, ld_cdb_flag, ld_cdb_val, ld_cdb_rob_id,
               eng_start, eng_wr, eng_addr, eng_width, eng_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the byte-serial RAM engine to IF or LSB one whole transaction at a time,
// LSB first with an IF anti-starvation limit, IO store stall and speculative flush.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          STARVE_MAX = 3
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int            CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, RUN_IF, RUN_LS, IO_WAIT, DRAIN} state_t;

    state_t        state, state_d;
    logic [CW-1:0] starve_cnt;
    logic          grant_if, grant_ls, start_d, fire_if, fire_ls, clr_starve;
    logic          io_stall, pick_ls, can_grant, flushable;

    assign io_stall  = bus.lsb_type && bus.lsb_addr >= IO_BASE && bus.io_buffer_full;
    assign pick_ls   = bus.lsb_req && (!bus.if_req || starve_cnt < SMAX);
    // a result pulse in flight forces a one-cycle gap before the next grant
    assign can_grant = !bus.jump_wrong && !bus.if_valid && !bus.lsb_done;
    assign flushable = bus.jump_wrong && (state == RUN_IF || (state == RUN_LS && !bus.eng_wr));

    always_comb begin
        state_d    = state;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        start_d    = 1'b0;
        fire_if    = 1'b0;
        fire_ls    = 1'b0;
        clr_starve = 1'b0;
        if (bus.rdy) begin
            case (state)
                IDLE: begin
                    clr_starve = bus.jump_wrong;
                    grant_ls   = can_grant && pick_ls;
                    grant_if   = can_grant && !pick_ls && bus.if_req;
                    start_d    = grant_if || (grant_ls && !io_stall);
                    state_d    = grant_ls ? (io_stall ? IO_WAIT : RUN_LS) : grant_if ? RUN_IF : IDLE;
                end
                RUN_IF, RUN_LS: begin
                    if (flushable) begin
                        state_d = bus.eng_done ? IDLE : DRAIN;
                    end else if (bus.eng_done) begin
                        fire_if = state == RUN_IF;
                        fire_ls = state == RUN_LS;
                        state_d = IDLE;
                    end
                end
                IO_WAIT: begin
                    start_d = !bus.io_buffer_full;
                    state_d = start_d ? RUN_LS : IO_WAIT;
                end
                DRAIN:   state_d = bus.eng_done ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_valid      <= 1'b0;
            bus.if_inst       <= '0;
            bus.lsb_done      <= 1'b0;
            bus.ld_cdb_flag   <= 1'b0;
            bus.ld_cdb_val    <= '0;
            bus.ld_cdb_rob_id <= '0;
            bus.eng_start     <= 1'b0;
            bus.eng_wr        <= 1'b0;
            bus.eng_addr      <= '0;
            bus.eng_width     <= '0;
            bus.eng_wdata     <= '0;
            starve_cnt        <= '0;
        end else begin
            bus.eng_start   <= start_d;
            bus.if_valid    <= fire_if;
            bus.lsb_done    <= fire_ls;
            bus.ld_cdb_flag <= fire_ls && !bus.eng_wr;
            if (fire_if) bus.if_inst <= bus.eng_rdata;
            if (fire_ls && !bus.eng_wr) bus.ld_cdb_val <= bus.eng_rdata;
            if (grant_if) begin
                bus.eng_wr    <= 1'b0;
                bus.eng_addr  <= bus.if_addr;
                bus.eng_width <= 2'd3;
                bus.eng_wdata <= '0;
            end
            if (grant_ls) begin
                bus.eng_wr        <= bus.lsb_type;
                bus.eng_addr      <= bus.lsb_addr;
                bus.eng_width     <= (bus.lsb_width == 2'd2) ? 2'd3 : bus.lsb_width;
                bus.eng_wdata     <= bus.lsb_val;
                bus.ld_cdb_rob_id <= bus.lsb_rob_id;
            end
            if (grant_if || clr_starve) starve_cnt <= '0;
            else if (grant_ls && bus.if_req && starve_cnt < SMAX) starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a fixed-latency engine model; expected results are queued
// when requests are driven and compared when IF/LSB result pulses appear.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ROB_W(4)) m ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(m));

    typedef struct {logic is_if; logic is_ld; logic [31:0] data; logic [3:0] rob;} exp_t;
    typedef struct {logic typ; logic [1:0] w; logic [31:0] addr; logic [31:0] val; logic [3:0] rob;} lreq_t;

    exp_t  sb[$];
    lreq_t lq[$];
    int n_vec = 0, n_fail = 0, cyc = 0, eng_cnt = -1;
    int start_cyc = 0, done_cyc = 0, lsb_done_cyc = 0;
    logic [31:0] eng_resp = '0;

    function automatic logic [31:0] mem_rd(logic [31:0] a, logic [1:0] w);
        logic [31:0] d;
        d = (a == 32'h100) ? 32'h0050_0093 : {a[15:0] ^ 16'h1234, a[15:0]};
        return w == 2'd0 ? d & 32'hff : w == 2'd1 ? d & 32'hffff : d;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive_lsb(lreq_t r);
        m.lsb_req    = 1'b1;
        m.lsb_type   = r.typ;
        m.lsb_width  = r.w;
        m.lsb_addr   = r.addr;
        m.lsb_val    = r.val;
        m.lsb_rob_id = r.rob;
    endtask

    task automatic push_lsb(logic typ, logic [1:0] w, logic [31:0] a, logic [31:0] v, logic [3:0] rob);
        lreq_t r;
        exp_t  e;
        r = '{typ, w, a, v, rob};
        e = '{1'b0, !typ, typ ? v : mem_rd(a, w), rob};
        lq.push_back(r);
        sb.push_back(e);
        if (!m.lsb_req) drive_lsb(lq.pop_front());
    endtask

    task automatic push_if(logic [31:0] a, logic expect_result);
        exp_t e;
        m.if_req  = 1'b1;
        m.if_addr = a;
        e = '{1'b1, 1'b0, mem_rd(a, 2'd3), 4'd0};
        if (expect_result) sb.push_back(e);
    endtask

    // one clock: check result pulses, retire requests, advance the engine model
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (m.if_valid || m.lsb_done) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {m.if_valid, m.lsb_done}, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {m.if_valid, m.lsb_done, m.ld_cdb_flag}, {e.is_if, !e.is_if, e.is_ld});
                if (e.is_if) check("if_inst", m.if_inst, e.data);
                else if (e.is_ld) begin
                    check("ld_val", m.ld_cdb_val, e.data);
                    check("ld_rob", m.ld_cdb_rob_id, e.rob);
                end
            end
            if (m.if_valid) m.if_req = 1'b0;
            if (m.lsb_done) begin
                lsb_done_cyc = cyc;
                if (lq.size() > 0) drive_lsb(lq.pop_front());
                else m.lsb_req = 1'b0;
            end
        end
        if (m.eng_start) start_cyc = cyc;
        if (rst) begin
            eng_cnt    = -1;
            m.eng_done = 1'b0;
        end else if (m.rdy) begin
            m.eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    m.eng_done  = 1'b1;
                    m.eng_rdata = eng_resp;
                    done_cyc    = cyc;
                end
            end
            if (m.eng_start) begin
                eng_cnt  = 4;
                eng_resp = mem_rd(m.eng_addr, m.eng_width);
            end
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!m.eng_start && n < 40);
        if (!m.eng_start) check("start_seen", m.eng_start, 1);
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < 100 && sb.size() > 0; k++) step();
        check(tag, sb.size(), 0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        m.rdy = 1'b1; m.io_buffer_full = 1'b0; m.jump_wrong = 1'b0;
        m.if_req = 1'b0; m.if_addr = '0;
        m.lsb_req = 1'b0; m.lsb_type = 1'b0; m.lsb_width = '0; m.lsb_addr = '0; m.lsb_val = '0; m.lsb_rob_id = '0;
        m.eng_done = 1'b0; m.eng_rdata = '0;
        repeat (3) step();
        check("rst_pulses", {m.if_valid, m.lsb_done, m.ld_cdb_flag, m.eng_start}, 0);
        check("rst_eng_addr", m.eng_addr, 0);
        check("rst_if_inst", m.if_inst, 0);
        check("rst_ld_val", m.ld_cdb_val, 0);
        rst = 1'b0;
        step();

        push_if(32'h100, 1'b1);
        wait_start(n);
        check("fetch_lat", n, 1);
        check("fetch_addr", m.eng_addr, 32'h100);
        check("fetch_width", m.eng_width, 3);
        check("fetch_wr", m.eng_wr, 0);
        drain("fetch_done");

        push_lsb(1'b0, 2'd3, 32'h200, 32'h0, 4'd5);
        push_if(32'h104, 1'b1);
        wait_start(n);
        check("cont_lat", n, 1);
        check("cont_ls_addr", m.eng_addr, 32'h200);
        wait_start(n);
        check("cont_if_addr", m.eng_addr, 32'h104);
        check("cont_gap", start_cyc - lsb_done_cyc, 2);
        drain("cont_done");

        push_lsb(1'b0, 2'd3, 32'h300, 32'h0, 4'd1);
        push_lsb(1'b0, 2'd3, 32'h304, 32'h0, 4'd2);
        push_lsb(1'b0, 2'd2, 32'h308, 32'h0, 4'd3);
        push_if(32'h108, 1'b1);
        push_lsb(1'b0, 2'd0, 32'h30d, 32'h0, 4'd4);
        drain("starve_done");

        m.io_buffer_full = 1'b1;
        push_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h41, 4'd0);
        n = 0;
        repeat (10) begin
            step();
            if (m.eng_start) n++;
        end
        check("io_hold", n, 0);
        m.io_buffer_full = 1'b0;
        wait_start(n);
        check("io_release", n, 1);
        check("io_wdata", m.eng_wdata, 32'h41);
        check("io_width", m.eng_width, 0);
        check("io_wr", m.eng_wr, 1);
        drain("io_done");

        push_if(32'h100, 1'b0);
        wait_start(n);
        step();
        step();
        m.jump_wrong = 1'b1;
        m.if_req = 1'b0;
        step();
        m.jump_wrong = 1'b0;
        push_if(32'h104, 1'b1);
        wait_start(n);
        check("flush_gap", start_cyc - done_cyc, 2);
        drain("flush_if_done");

        push_lsb(1'b1, 2'd3, 32'h400, 32'hdead_beef, 4'd0);
        wait_start(n);
        check("st_wdata", m.eng_wdata, 32'hdead_beef);
        step();
        step();
        m.jump_wrong = 1'b1;
        step();
        m.jump_wrong = 1'b0;
        drain("flush_st_done");

        push_lsb(1'b0, 2'd1, 32'h502, 32'h0, 4'd9);
        wait_start(n);
        step();
        m.rdy = 1'b0;
        n = 0;
        repeat (5) begin
            step();
            n += int'(m.eng_start | m.lsb_done | m.if_valid);
        end
        check("rdy_pulses", n, 0);
        check("rdy_hold_addr", m.eng_addr, 32'h502);
        m.rdy = 1'b1;
        drain("rdy_done");

        m.rdy = 1'b0;
        push_if(32'h108, 1'b1);
        n = 0;
        repeat (3) begin
            step();
            if (m.eng_start) n++;
        end
        check("rdy_no_grant", n, 0);
        m.rdy = 1'b1;
        wait_start(n);
        check("rdy_resume_lat", n, 1);
        drain("rdy_resume_done");

        push_if(32'h100, 1'b0);
        wait_start(n);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_addr", m.eng_addr, 0);
        check("arst_width_wr", {m.eng_width, m.eng_wr}, 0);
        m.if_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        push_if(32'h104, 1'b1);
        wait_start(n);
        check("post_rst_lat", n, 1);
        drain("post_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
